alu_issue_ctrl: RTL and testbench

Issue and writeback controller that sits directly upstream of the combinational 16-bit ALU (`ALU_16_bits`). It accepts one ALU instruction per handshake and reads operands from an internal 8×16 register file. It drives the ALU's A/B/F/Cin from registered values, then writes Result back to the register file and latches Status into a flags register. The stored carry flag feeds Cin for carry/borrow/rotate-through-carry operations.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 110 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and legality definitions for the 16-bit ALU and its issue controller.
package alu_pkg;

    localparam int unsigned OPW    = 5;
    localparam int unsigned NFLAGS = 6;

    localparam logic [OPW-1:0] OP_INC = 5'b00001;
    localparam logic [OPW-1:0] OP_DEC = 5'b00011;
    localparam logic [OPW-1:0] OP_ADD = 5'b00100;
    localparam logic [OPW-1:0] OP_ADC = 5'b00101;
    localparam logic [OPW-1:0] OP_SUB = 5'b00110;
    localparam logic [OPW-1:0] OP_SBB = 5'b00111;
    localparam logic [OPW-1:0] OP_AND = 5'b01000;
    localparam logic [OPW-1:0] OP_OR  = 5'b01001;
    localparam logic [OPW-1:0] OP_XOR = 5'b01010;
    localparam logic [OPW-1:0] OP_NOT = 5'b01011;
    localparam logic [OPW-1:0] OP_SHL = 5'b10000;
    localparam logic [OPW-1:0] OP_SHR = 5'b10001;
    localparam logic [OPW-1:0] OP_SAL = 5'b10010;
    localparam logic [OPW-1:0] OP_SAR = 5'b10011;
    localparam logic [OPW-1:0] OP_ROL = 5'b10100;
    localparam logic [OPW-1:0] OP_ROR = 5'b10101;
    localparam logic [OPW-1:0] OP_RCL = 5'b10110;
    localparam logic [OPW-1:0] OP_RCR = 5'b10111;

    localparam int unsigned FLG_C  = 0;
    localparam int unsigned FLG_Z  = 1;
    localparam int unsigned FLG_S  = 2;
    localparam int unsigned FLG_V  = 3;
    localparam int unsigned FLG_AC = 4;
    localparam int unsigned FLG_P  = 5;

    // Arithmetic, logic and shift groups each occupy an aligned block of codes.
    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return (op == OP_INC) || (op == OP_DEC) ||
               (op[4:2] == 3'b001) || (op[4:2] == 3'b010) || (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, a debug read port, one synchronous write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] ra1,
    output logic [W-1:0]             rd1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [W-1:0]             rd2,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [W-1:0]             dbg_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [W-1:0]             wd
);

    logic [W-1:0] mem_q [NREGS];

    assign rd1      = mem_q[ra1];
    assign rd2      = mem_q[ra2];
    assign dbg_data = mem_q[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the external 16-bit ALU: two-cycle accept/execute loop,
// register-file writeback and architectural flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_op,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs1,
    input  logic [$clog2(NREGS)-1:0] in_rs2,
    input  logic [W-1:0]             in_imm,
    input  logic                     in_use_imm,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [OPW-1:0]           alu_f,
    output logic                     alu_cin,
    input  logic [W-1:0]             alu_result,
    input  logic [NFLAGS-1:0]        alu_status,
    output logic [NFLAGS-1:0]        flags,
    output logic                     done,
    output logic [W-1:0]             done_data,
    output logic                     illegal,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [W-1:0]             dbg_data
);

    localparam int unsigned AW = $clog2(NREGS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0]    state_q;
    logic          rdy_q;
    logic [AW-1:0] rd_q;
    logic [W-1:0]  rs1_data;
    logic [W-1:0]  rs2_data;
    logic          wb_en;

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready = (state_q == ST_IDLE) && rdy_q;
    assign wb_en    = (state_q == ST_EXEC) && is_legal_op(alu_f);

    alu_regfile #(
        .NREGS (NREGS),
        .W     (W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (in_rs1),
        .rd1      (rs1_data),
        .ra2      (in_rs2),
        .rd2      (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_en),
        .wa       (rd_q),
        .wd       (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b0;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            alu_cin   <= 1'b0;
            flags     <= '0;
            done      <= 1'b0;
            done_data <= '0;
            illegal   <= 1'b0;
        end else begin
            rdy_q     <= 1'b1;
            done      <= 1'b0;
            done_data <= '0;
            illegal   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        alu_a   <= rs1_data;
                        alu_b   <= in_use_imm ? in_imm : rs2_data;
                        alu_f   <= in_op;
                        alu_cin <= flags[FLG_C];
                        rd_q    <= in_rd;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b1;
                    if (is_legal_op(alu_f)) begin
                        flags     <= alu_status;
                        done_data <= alu_result;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a transaction-level model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [15:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [5:0]  alu_status, flags;
    logic        done, illegal;
    logic [15:0] done_data;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NREGS(8), .W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .flags      (flags),
        .done       (done),
        .done_data  (done_data),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU: returns {P, AC, V, S, Z, C, result}.
    function automatic logic [21:0] alu_fn(input logic [4:0] f, input logic [15:0] a,
                                           input logic [15:0] b, input logic ci);
        logic [16:0] s, c17;
        logic [15:0] r;
        logic        c, v, ac;
        r = a; c = 1'b0; v = 1'b0; ac = 1'b0; s = '0;
        c17 = {16'b0, f[0] & ci};
        case (f)
            5'b00001: begin
                s = {1'b0, a} + 17'd1; r = s[15:0]; c = s[16];
                ac = (a[3:0] == 4'hF); v = (a == 16'h7FFF);
            end
            5'b00011: begin
                s = {1'b0, a} - 17'd1; r = s[15:0]; c = s[16];
                ac = (a[3:0] == 4'h0); v = (a == 16'h8000);
            end
            5'b00100, 5'b00101: begin
                s = {1'b0, a} + {1'b0, b} + c17; r = s[15:0]; c = s[16];
                ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + c17[4:0]) > 5'd15;
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'b00110, 5'b00111: begin
                s = {1'b0, a} - {1'b0, b} - c17; r = s[15:0]; c = s[16];
                ac = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + c17[4:0]);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'b01000: r = a & b;
            5'b01001: r = a | b;
            5'b01010: r = a ^ b;
            5'b01011: r = ~a;
            5'b10000, 5'b10010: begin r = {a[14:0], 1'b0}; c = a[15]; end
            5'b10001: begin r = {1'b0, a[15:1]}; c = a[0]; end
            5'b10011: begin r = {a[15], a[15:1]}; c = a[0]; end
            5'b10100: begin r = {a[14:0], a[15]}; c = a[15]; end
            5'b10101: begin r = {a[0], a[15:1]}; c = a[0]; end
            5'b10110: begin r = {a[14:0], ci}; c = a[15]; end
            5'b10111: begin r = {ci, a[15:1]}; c = a[0]; end
            default: return {6'h3F, 16'hDEAD};
        endcase
        return {~^r[7:0], ac, v, r[15], (r == 16'h0), c, r};
    endfunction

    function automatic logic op_is_legal(input logic [4:0] f);
        return f inside {5'd1, 5'd3, [5'd4:5'd11], [5'd16:5'd23]};
    endfunction

    assign {alu_status, alu_result} = alu_fn(alu_f, alu_a, alu_b, alu_cin);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: accept when ready, write back one edge later.
    logic [15:0] m_regs [8];
    logic [5:0]  m_flags;
    logic        m_ready, m_busy, m_done, m_illegal, m_cin;
    logic [15:0] m_ddata, m_a, m_b;
    logic [4:0]  m_f;
    logic [2:0]  m_rd;
    logic [21:0] m_res;
    int          cyc = 0;
    int          acc_n, acc_last, acc_prev;

    assign m_res = alu_fn(m_f, m_a, m_b, m_cin);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= '0;
            m_flags <= '0; m_ready <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_illegal <= 1'b0; m_ddata <= '0; m_a <= '0; m_b <= '0; m_f <= '0;
            m_cin <= 1'b0; m_rd <= '0;
        end else begin
            m_done <= 1'b0; m_illegal <= 1'b0; m_ddata <= '0;
            if (m_busy) begin
                m_busy <= 1'b0; m_ready <= 1'b1; m_done <= 1'b1;
                if (op_is_legal(m_f)) begin
                    m_regs[m_rd] <= m_res[15:0];
                    m_flags      <= m_res[21:16];
                    m_ddata      <= m_res[15:0];
                end else begin
                    m_illegal <= 1'b1;
                end
            end else if (m_ready && in_valid) begin
                m_a <= m_regs[in_rs1];
                m_b <= in_use_imm ? in_imm : m_regs[in_rs2];
                m_f <= in_op; m_cin <= m_flags[0]; m_rd <= in_rd;
                m_busy <= 1'b1; m_ready <= 1'b0;
                acc_n <= acc_n + 1; acc_prev <= acc_last; acc_last <= cyc;
            end else begin
                m_ready <= 1'b1;
            end
        end
    end

    initial begin
        acc_n = 0; acc_last = 0; acc_prev = 0;
    end

    always @(negedge clk) begin
        check("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
        check("done", {31'b0, done}, {31'b0, m_done});
        if (m_done) begin
            check("illegal", {31'b0, illegal}, {31'b0, m_illegal});
            check("done_data", {16'b0, done_data}, {16'b0, m_ddata});
        end
        check("flags", {26'b0, flags}, {26'b0, m_flags});
        check("alu_a", {16'b0, alu_a}, {16'b0, m_a});
        check("alu_b", {16'b0, alu_b}, {16'b0, m_b});
        check("alu_f", {27'b0, alu_f}, {27'b0, m_f});
        check("alu_cin", {31'b0, alu_cin}, {31'b0, m_cin});
        check("dbg_data", {16'b0, dbg_data}, {16'b0, m_regs[dbg_addr]});
    end

    logic last_cin;
    logic last_ready;

    // Called just after a rising edge; returns just after the writeback edge.
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm, input logic use_imm);
        bit got;
        got = 1'b0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_use_imm = use_imm; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept, expected accept within 20 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_cin = alu_cin; last_ready = in_ready;
        @(posedge clk); #1;
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] exp, input string name);
        dbg_addr = a; #1;
        check(name, {16'b0, dbg_data}, {16'b0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int prev_n;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        check("rst_flags", {26'b0, flags}, 32'd0);
        check("rst_alu_a", {16'b0, alu_a}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);

        // ADD after reset
        issue(5'b00100, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b1);
        issue(5'b00100, 3'd2, 3'd0, 3'd0, 16'h0004, 1'b1);
        issue(5'b00100, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
        check("add_done", {31'b0, done}, 32'd1);
        check("add_data", {16'b0, done_data}, 32'h0009);
        check("add_c", {31'b0, flags[0]}, 32'd0);
        check("exec_ready_low", {31'b0, last_ready}, 32'd0);
        check_reg(3'd3, 16'h0009, "r3_add");

        // Carry feed into ADC
        issue(5'b00100, 3'd4, 3'd0, 3'd0, 16'hFFFF, 1'b1);
        issue(5'b00100, 3'd5, 3'd4, 3'd0, 16'h0001, 1'b1);
        check("carry_data", {16'b0, done_data}, 32'h0000);
        check("carry_c", {31'b0, flags[0]}, 32'd1);
        check("carry_z", {31'b0, flags[1]}, 32'd1);
        issue(5'b00101, 3'd6, 3'd1, 3'd0, 16'h0004, 1'b1);
        check("adc_cin", {31'b0, last_cin}, 32'd1);
        check_reg(3'd6, 16'h000A, "r6_adc");
        check("adc_flags", {26'b0, flags}, 32'h20);

        // Illegal opcode
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
        check("ill_done", {31'b0, done}, 32'd1);
        check("ill_flag", {31'b0, illegal}, 32'd1);
        check("ill_data", {16'b0, done_data}, 32'd0);
        check("ill_flags_kept", {26'b0, flags}, 32'h20);
        check_reg(3'd3, 16'h0009, "r3_kept");

        // Back-to-back INC with in_valid held high
        issue(5'b00100, 3'd1, 3'd0, 3'd0, 16'h000F, 1'b1);
        start = acc_n; prev_n = acc_n;
        in_op = 5'b00001; in_rd = 3'd1; in_rs1 = 3'd1; in_rs2 = 3'd0; in_use_imm = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (acc_n != prev_n) check("b2b_ready_low", {31'b0, in_ready}, 32'd0);
            prev_n = acc_n;
            if (acc_n == start + 2) break;
        end
        in_valid = 1'b0;
        check("b2b_count", acc_n - start, 32'd2);
        check("b2b_spacing", acc_last - acc_prev, 32'd2);
        @(posedge clk); #1;
        check_reg(3'd1, 16'h0011, "r1_b2b");

        // RCL with carry set
        issue(5'b00100, 3'd2, 3'd0, 3'd0, 16'h7521, 1'b1);
        issue(5'b00100, 3'd7, 3'd4, 3'd0, 16'h0001, 1'b1);
        check("rcl_pre_c", {31'b0, flags[0]}, 32'd1);
        issue(5'b10110, 3'd3, 3'd2, 3'd0, 16'h0000, 1'b1);
        check("rcl_cin", {31'b0, last_cin}, 32'd1);
        check("rcl_data", {16'b0, done_data}, 32'hEA43);
        check_reg(3'd3, 16'hEA43, "r3_rcl");

        // Reset during EXEC
        in_op = 5'b00100; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2; in_use_imm = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_ready) break;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        check("abort_flags", {26'b0, flags}, 32'd0);
        check_reg(3'd3, 16'h0000, "r3_abort");
        @(posedge clk); #1;
        check("abort_no_late_done", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
